// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock/strobe divider with shadowed reload
module clk_div_bank #(
    parameter int          N_CH       = 2,
    parameter int          CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 1,
    parameter int unsigned RST_HIGH   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH-1:0]         EN,
    input  logic [N_CH*CNT_W-1:0]   PERIOD_IN,
    input  logic [N_CH*CNT_W-1:0]   HIGH_IN,
    input  logic [N_CH-1:0]         LOAD,
    input  logic                    SYNC,
    output logic [N_CH-1:0]         CLK_OUT,
    output logic [N_CH-1:0]         TICK,
    output logic [N_CH-1:0]         PEND
);

    localparam logic [CNT_W-1:0] RST_PER_V  = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH_V = CNT_W'(RST_HIGH);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q,    cnt_d;
        logic [CNT_W-1:0] per_a_q,  per_a_d;
        logic [CNT_W-1:0] high_a_q, high_a_d;
        logic [CNT_W-1:0] per_p_q,  per_p_d;
        logic [CNT_W-1:0] high_p_q, high_p_d;
        logic             pend_q,   pend_d;
        logic             tick_q,   tick_d;
        logic             out_q,    out_d;
        logic             wrap;
        logic             apply;

        // Next-state: pending capture, wrap/park decision, shadow apply and output level
        always_comb begin
            cnt_d    = cnt_q;
            per_a_d  = per_a_q;
            high_a_d = high_a_q;
            per_p_d  = per_p_q;
            high_p_d = high_p_q;
            pend_d   = pend_q;
            tick_d   = 1'b0;
            out_d    = 1'b0;
            wrap     = 1'b0;
            apply    = 1'b0;

            // A disabled channel applies pending values immediately; an enabled
            // one only at a wrap, so the running period is never cut short.
            if (!EN[i]) begin
                apply = pend_q;
            end else begin
                wrap  = (cnt_q == per_a_q) || SYNC;
                apply = wrap && pend_q;
            end

            if (apply) begin
                per_a_d  = per_p_q;
                high_a_d = high_p_q;
                pend_d   = 1'b0;
            end

            // A LOAD on the apply edge lands in pending and survives to the next apply
            if (LOAD[i]) begin
                per_p_d  = PERIOD_IN[i*CNT_W +: CNT_W];
                high_p_d = HIGH_IN[i*CNT_W +: CNT_W];
                pend_d   = 1'b1;
            end

            if (!EN[i]) begin
                // Parking at terminal count makes the first enabled edge a wrap
                cnt_d = per_a_d;
            end else if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                out_d  = (cnt_d < high_a_d);
            end else begin
                cnt_d  = cnt_q + ONE;
                out_d  = (cnt_d < high_a_d);
            end
        end

        // Channel state register with synchronous reset to the parked defaults
        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_q    <= RST_PER_V;
                per_a_q  <= RST_PER_V;
                high_a_q <= RST_HIGH_V;
                per_p_q  <= RST_PER_V;
                high_p_q <= RST_HIGH_V;
                pend_q   <= 1'b0;
                tick_q   <= 1'b0;
                out_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                per_a_q  <= per_a_d;
                high_a_q <= high_a_d;
                per_p_q  <= per_p_d;
                high_p_q <= high_p_d;
                pend_q   <= pend_d;
                tick_q   <= tick_d;
                out_q    <= out_d;
            end
        end

        assign CLK_OUT[i] = out_q;
        assign TICK[i]    = tick_q;
        assign PEND[i]    = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed scoreboard bench for clk_div_bank
module tb_clk_div_bank;

    localparam int N_CH  = 2;
    localparam int CNT_W = 32;

    logic                  CLK;
    logic                  RST;
    logic [N_CH-1:0]       EN;
    logic [N_CH*CNT_W-1:0] PERIOD_IN;
    logic [N_CH*CNT_W-1:0] HIGH_IN;
    logic [N_CH-1:0]       LOAD;
    logic                  SYNC;
    logic [N_CH-1:0]       CLK_OUT;
    logic [N_CH-1:0]       TICK;
    logic [N_CH-1:0]       PEND;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    ch;
        logic  o;
        logic  t;
        logic  p;
    } exp_t;

    exp_t sb[$];

    clk_div_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .RST_PERIOD(1), .RST_HIGH(1)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .PERIOD_IN(PERIOD_IN), .HIGH_IN(HIGH_IN),
        .LOAD(LOAD), .SYNC(SYNC), .CLK_OUT(CLK_OUT), .TICK(TICK), .PEND(PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic e1(input string tag, input int ch, input logic o, input logic t, input logic p);
        exp_t e;
        e.tag = tag; e.ch = ch; e.o = o; e.t = t; e.p = p;
        sb.push_back(e);
    endtask

    task automatic e2(input string tag, input logic o0, input logic t0, input logic p0,
                      input logic o1, input logic t1, input logic p1);
        e1(tag, 0, o0, t0, p0);
        e1(tag, 1, o1, t1, p1);
    endtask

    task automatic set_ch(input int ch, input int unsigned per, input int unsigned high);
        PERIOD_IN[ch*CNT_W +: CNT_W] = per;
        HIGH_IN[ch*CNT_W +: CNT_W]   = high;
    endtask

    // Advance one edge, sample 1 time unit later, drain the scoreboard, drop strobes
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (CLK_OUT[e.ch] === e.o) else begin
                errors++;
                $error("FAIL %s ch%0d CLK_OUT got %b exp %b", e.tag, e.ch, CLK_OUT[e.ch], e.o);
            end
            checks++;
            assert (TICK[e.ch] === e.t) else begin
                errors++;
                $error("FAIL %s ch%0d TICK got %b exp %b", e.tag, e.ch, TICK[e.ch], e.t);
            end
            checks++;
            assert (PEND[e.ch] === e.p) else begin
                errors++;
                $error("FAIL %s ch%0d PEND got %b exp %b", e.tag, e.ch, PEND[e.ch], e.p);
            end
        end
        LOAD = '0;
        SYNC = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = '0; LOAD = '0; SYNC = 1'b0;
        PERIOD_IN = '0; HIGH_IN = '0;

        // Reset state
        e2("reset", 0, 0, 0, 0, 0, 0); step();

        // 1: defaults give CLK/2, first TICK on the first enabled edge
        RST = 1'b0; EN = 2'b01;
        for (int k = 0; k < 7; k++) begin
            e1("t1_ch0", 0, (k % 2) == 0, (k % 2) == 0, 1'b0);
            e1("t1_ch1_off", 1, 1'b0, 1'b0, 1'b0);
            step();
        end

        // 2: mid-period LOAD per=4 high=2; old period completes, then 1,1,0,0,0
        set_ch(0, 4, 2); LOAD = 2'b01;
        e1("t2_load", 0, 0, 0, 1); step();
        e1("t2_apply", 0, 1, 1, 0); step();
        e1("t2_c1", 0, 1, 0, 0); step();
        e1("t2_c2", 0, 0, 0, 0); step();
        e1("t2_c3", 0, 0, 0, 0); step();
        e1("t2_c4", 0, 0, 0, 0); step();
        e1("t2_wrap", 0, 1, 1, 0); step();
        e1("t2_c1b", 0, 1, 0, 0); step();
        e1("t2_c2b", 0, 0, 0, 0); step();

        // 3: ch1 per=3 high=0 (loaded while disabled), then high=9
        set_ch(1, 3, 0); LOAD = 2'b10;
        e1("t3_cap_off", 1, 0, 0, 1); step();
        e1("t3_apply_off", 1, 0, 0, 0); step();
        EN = 2'b11;
        e1("t3_start", 1, 0, 1, 0); step();
        set_ch(1, 3, 9); LOAD = 2'b10;
        e1("t3_h0_c1", 1, 0, 0, 1); step();
        e1("t3_h0_c2", 1, 0, 0, 1); step();
        e1("t3_h0_c3", 1, 0, 0, 1); step();
        e1("t3_h9_wrap", 1, 1, 1, 0); step();
        e1("t3_h9_c1", 1, 1, 0, 0); step();
        e1("t3_h9_c2", 1, 1, 0, 0); step();
        e1("t3_h9_c3", 1, 1, 0, 0); step();
        e1("t3_h9_wrap2", 1, 1, 1, 0); step();

        // 4: ch1 per=6 high=3 pending, SYNC aligns both channels
        set_ch(1, 6, 3); LOAD = 2'b10;
        e1("t4_load", 1, 1, 0, 1); step();
        e2("t4_pre", 1, 1, 0, 1, 0, 1); step();
        SYNC = 1'b1;
        e2("t4_sync", 1, 1, 0, 1, 1, 0); step();
        e2("t4_k1", 1, 0, 0, 1, 0, 0); step();
        e2("t4_k2", 0, 0, 0, 1, 0, 0); step();
        e2("t4_k3", 0, 0, 0, 0, 0, 0); step();
        e2("t4_k4", 0, 0, 0, 0, 0, 0); step();
        e2("t4_k5", 1, 1, 0, 0, 0, 0); step();
        e2("t4_k6", 1, 0, 0, 0, 0, 0); step();
        e2("t4_k7", 0, 0, 0, 1, 1, 0); step();
        e2("t4_k8", 0, 0, 0, 1, 0, 0); step();
        e2("t4_k9", 0, 0, 0, 1, 0, 0); step();
        SYNC = 1'b1;
        e2("t4_sync_tc", 1, 1, 0, 1, 1, 0); step();
        e2("t4_no_dbl", 1, 0, 0, 1, 0, 0); step();

        // 5: LOAD on the exact wrap edge (per 2 -> 7)
        EN = 2'b01;
        set_ch(0, 2, 1); LOAD = 2'b01;
        e1("t5_p2_load", 0, 0, 0, 1); step();
        e1("t5_p2_w1", 0, 0, 0, 1); step();
        e1("t5_p2_w2", 0, 0, 0, 1); step();
        e1("t5_p2_apply", 0, 1, 1, 0); step();
        e1("t5_p2_c1", 0, 0, 0, 0); step();
        e1("t5_p2_c2", 0, 0, 0, 0); step();
        set_ch(0, 7, 3); LOAD = 2'b01;
        e1("t5_wrap_load", 0, 1, 1, 1); step();
        e1("t5_old_c1", 0, 0, 0, 1); step();
        e1("t5_old_c2", 0, 0, 0, 1); step();
        e1("t5_new_apply", 0, 1, 1, 0); step();
        e1("t5_new_c1", 0, 1, 0, 0); step();
        e1("t5_new_c2", 0, 1, 0, 0); step();
        e1("t5_new_c3", 0, 0, 0, 0); step();

        // 6: EN drop mid-high, LOAD while disabled, restart, then RST mid-run
        for (int k = 0; k < 4; k++) begin
            e1("t6_run", 0, 0, 0, 0); step();
        end
        e1("t6_wrap", 0, 1, 1, 0); step();
        e1("t6_high", 0, 1, 0, 0); step();
        EN = 2'b00;
        e1("t6_drop", 0, 0, 0, 0); step();
        set_ch(0, 3, 2); LOAD = 2'b01;
        e1("t6_load_off", 0, 0, 0, 1); step();
        e1("t6_apply_off", 0, 0, 0, 0); step();
        EN = 2'b01;
        e1("t6_restart", 0, 1, 1, 0); step();
        e1("t6_r_c1", 0, 1, 0, 0); step();
        e1("t6_r_c2", 0, 0, 0, 0); step();
        e1("t6_r_c3", 0, 0, 0, 0); step();
        e1("t6_r_wrap", 0, 1, 1, 0); step();
        EN = 2'b11; RST = 1'b1;
        e2("t6_rst", 0, 0, 0, 0, 0, 0); step();
        RST = 1'b0; EN = 2'b01;
        e2("t6_def1", 1, 1, 0, 0, 0, 0); step();
        e1("t6_def2", 0, 0, 0, 0); step();
        e1("t6_def3", 0, 1, 1, 0); step();

        // per_a = 0: wraps every cycle, TICK held high, CLK_OUT constant
        set_ch(1, 0, 1); LOAD = 2'b10;
        e1("p0_cap", 1, 0, 0, 1); step();
        e1("p0_apply", 1, 0, 0, 0); step();
        EN = 2'b11;
        for (int k = 0; k < 3; k++) begin
            e1("p0_run", 1, 1, 1, 0); step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
